// File: rtl/imm_pkg.sv
// Immediate format codes and instruction field geometry for the immediate
// extension pipeline.
package imm_pkg;

  typedef enum logic [2:0] {
    RTYPE  = 3'd0,
    ITYPE  = 3'd1,
    STYPE  = 3'd2,
    BTYPE  = 3'd3,
    UTYPE  = 3'd4,
    JTYPE  = 3'd5,
    ZTYPE  = 3'd6,
    SHTYPE = 3'd7
  } imm_type_e;

  // Only instruction bits [31:7] carry immediate or zimm/shamt fields.
  localparam int INST_LSB = 7;
  localparam int INST_W   = 32 - INST_LSB;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational RISC-V immediate decoder: forms the XLEN-wide immediate and an
// illegal flag for shift encodings that do not fit the datapath.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INST_W-1:0] i_inst,
  input  logic [2:0]        i_imm_type,
  output logic [XLEN-1:0]   o_imm,
  output logic              o_illegal
);

  logic [31:INST_LSB] w_ins;
  assign w_ins = i_inst;

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
    return XLEN'(v);
  endfunction

  always_comb begin
    o_imm     = '0;
    o_illegal = 1'b0;
    case (imm_type_e'(i_imm_type))
      ITYPE:  o_imm = sext32({{20{w_ins[31]}}, w_ins[31:20]});
      STYPE:  o_imm = sext32({{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]});
      BTYPE:  o_imm = sext32({{19{w_ins[31]}}, w_ins[31], w_ins[7],
                              w_ins[30:25], w_ins[11:8], 1'b0});
      UTYPE:  o_imm = sext32({w_ins[31:12], 12'b0});
      JTYPE:  o_imm = sext32({{11{w_ins[31]}}, w_ins[31], w_ins[19:12],
                              w_ins[20], w_ins[30:21], 1'b0});
      ZTYPE:  o_imm = zext6({1'b0, w_ins[19:15]});
      SHTYPE: begin
        // RV32 shifts have a 5-bit shamt; a set bit 25 is a reserved encoding.
        if (XLEN == 64) begin
          o_imm = zext6(w_ins[25:20]);
        end else begin
          o_imm     = zext6({1'b0, w_ins[24:20]});
          o_illegal = w_ins[25];
        end
      end
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a main/skid register pair so that
// in_ready depends only on registered state.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [2:0]        in_imm_type,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal
);

  logic [XLEN-1:0]  w_imm_p0;
  logic             w_ill_p0;

  logic             r_main_vld_p1;
  logic [XLEN-1:0]  r_main_imm_p1;
  logic [TAG_W-1:0] r_main_tag_p1;
  logic             r_main_ill_p1;

  logic             r_skid_vld_p1;
  logic [XLEN-1:0]  r_skid_imm_p1;
  logic [TAG_W-1:0] r_skid_tag_p1;
  logic             r_skid_ill_p1;

  logic w_acc;
  logic w_xfer;
  logic w_main_vld_nxt;
  logic w_skid_vld_nxt;
  logic w_main_load_in;
  logic w_main_load_skid;
  logic w_skid_load;

  // Stage p0: combinational extension of the offered entry
  imm_extend_core #(
    .XLEN (XLEN)
  ) u_core (
    .i_inst     (in_inst),
    .i_imm_type (in_imm_type),
    .o_imm      (w_imm_p0),
    .o_illegal  (w_ill_p0)
  );

  assign in_ready = ~r_skid_vld_p1;
  assign w_acc    = in_valid & in_ready;
  assign w_xfer   = r_main_vld_p1 & out_ready;

  always_comb begin
    w_main_vld_nxt   = r_main_vld_p1;
    w_skid_vld_nxt   = r_skid_vld_p1;
    w_main_load_in   = 1'b0;
    w_main_load_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (flush) begin
      w_main_vld_nxt = 1'b0;
      w_skid_vld_nxt = 1'b0;
    end else if (r_skid_vld_p1) begin
      // in_ready is low here, so no new entry can arrive this cycle.
      if (w_xfer) begin
        w_main_load_skid = 1'b1;
        w_skid_vld_nxt   = 1'b0;
      end
    end else if (!r_main_vld_p1 || w_xfer) begin
      w_main_load_in = w_acc;
      w_main_vld_nxt = w_acc;
    end else if (w_acc) begin
      w_skid_load    = 1'b1;
      w_skid_vld_nxt = 1'b1;
    end
  end

  // Stage p1: main and skid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_vld_p1 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else begin
      r_main_vld_p1 <= w_main_vld_nxt;
      r_skid_vld_p1 <= w_skid_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_imm_p1 <= '0;
      r_main_tag_p1 <= '0;
      r_main_ill_p1 <= 1'b0;
    end else if (w_main_load_in) begin
      r_main_imm_p1 <= w_imm_p0;
      r_main_tag_p1 <= in_tag;
      r_main_ill_p1 <= w_ill_p0;
    end else if (w_main_load_skid) begin
      r_main_imm_p1 <= r_skid_imm_p1;
      r_main_tag_p1 <= r_skid_tag_p1;
      r_main_ill_p1 <= r_skid_ill_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_skid_load) begin
      r_skid_imm_p1 <= w_imm_p0;
      r_skid_tag_p1 <= in_tag;
      r_skid_ill_p1 <= w_ill_p0;
    end
  end

  assign out_valid   = r_main_vld_p1;
  assign out_imm     = r_main_imm_p1;
  assign out_tag     = r_main_tag_p1;
  assign out_illegal = r_main_ill_p1;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are compared against a queue-based reference model.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  typ;
    logic [4:0]  tag;
  } ent_t;

  logic rst, flush, in_valid, out_ready;
  ent_t cur;
  ent_t q[$];

  logic [24:0] in_inst;
  logic [2:0]  in_type;
  logic [4:0]  in_tag;
  assign in_inst = cur.inst[31:7];
  assign in_type = cur.typ;
  assign in_tag  = cur.tag;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  imm_extend_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_imm_type(in_type), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32),
    .out_illegal(ill32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_imm_type(in_type), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64),
    .out_illegal(ill64)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Immediate value computed from the ISA field definitions with shifts/masks.
  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] typ,
                                          input bit x64);
    logic [63:0] sg;
    sg = inst[31] ? '1 : '0;
    case (typ)
      3'd1: return (sg << 12) | 64'(inst >> 20);
      3'd2: return (sg << 12) | 64'(((inst >> 25) << 5) | ((inst >> 7) & 32'h1F));
      3'd3: return (sg << 12) | 64'((((inst >> 7) & 32'h1) << 11) |
                                    (((inst >> 25) & 32'h3F) << 5) |
                                    (((inst >> 8) & 32'hF) << 1));
      3'd4: return (sg << 32) | 64'(inst & 32'hFFFFF000);
      3'd5: return (sg << 20) | 64'((((inst >> 12) & 32'hFF) << 12) |
                                    (((inst >> 20) & 32'h1) << 11) |
                                    (((inst >> 21) & 32'h3FF) << 1));
      3'd6: return 64'((inst >> 15) & 32'h1F);
      3'd7: return x64 ? 64'((inst >> 20) & 32'h3F) : 64'((inst >> 20) & 32'h1F);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_ill(input logic [31:0] inst, input logic [2:0] typ,
                                   input bit x64);
    return (typ == 3'd7) && !x64 && inst[25];
  endfunction

  task automatic check_outputs();
    logic [63:0] e32, e64;
    chk("vld32", 64'(vld32), 64'(q.size() > 0));
    chk("vld64", 64'(vld64), 64'(q.size() > 0));
    chk("rdy32", 64'(rdy32), 64'(q.size() < 2));
    chk("rdy64", 64'(rdy64), 64'(q.size() < 2));
    if (q.size() > 0) begin
      e32 = ref_imm(q[0].inst, q[0].typ, 1'b0);
      e64 = ref_imm(q[0].inst, q[0].typ, 1'b1);
      chk("imm32", 64'(imm32), 64'(e32[31:0]));
      chk("imm64", imm64, e64);
      chk("tag32", 64'(tag32), 64'(q[0].tag));
      chk("tag64", 64'(tag64), 64'(q[0].tag));
      chk("ill32", 64'(ill32), 64'(ref_ill(q[0].inst, q[0].typ, 1'b0)));
      chk("ill64", 64'(ill64), 64'(ref_ill(q[0].inst, q[0].typ, 1'b1)));
    end
  endtask

  // One clock: decide handshakes from pre-edge state, advance model, check.
  task automatic cycle();
    bit acc, xf;
    acc = in_valid && (q.size() < 2);
    xf  = (q.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (xf) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    check_outputs();
  endtask

  task automatic push(input logic [31:0] inst, input logic [2:0] typ, input logic [4:0] tag);
    cur.inst = inst;
    cur.typ  = typ;
    cur.tag  = tag;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && q.size() > 0; k++) cycle();
    chk("drain_vld32", 64'(vld32), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cur.inst = '0; cur.typ = '0; cur.tag = '0;
    cycle();
    cycle();
    chk("rst_imm32", 64'(imm32), 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_tag32", 64'(tag32), 64'd0);
    chk("rst_ill32", 64'(ill32), 64'd0);
    rst = 1'b0;

    push(32'hFFF00093, ITYPE, 5'd4);
    chk("itype_imm32", 64'(imm32), 64'hFFFFFFFF);
    chk("itype_ill32", 64'(ill32), 64'd0);
    drain();
    push(32'hFE000EE3, BTYPE, 5'd5);
    chk("btype_imm32", 64'(imm32), 64'hFFFFFFFC);
    drain();
    push(32'h0080006F, JTYPE, 5'd6);
    chk("jtype_imm32", 64'(imm32), 64'h00000008);
    drain();
    push(32'h800000B7, UTYPE, 5'd7);
    chk("utype_imm64", imm64, 64'hFFFFFFFF80000000);
    drain();
    push(32'h000F8073, ZTYPE, 5'd8);
    chk("ztype_imm64", imm64, 64'h1F);
    drain();
    push(32'h03F00013, SHTYPE, 5'd9);
    chk("sh_imm64", imm64, 64'h3F);
    chk("sh_ill64", 64'(ill64), 64'd0);
    chk("sh_ill32", 64'(ill32), 64'd1);
    drain();

    // Back-pressure: third entry must wait in the input port.
    push(32'h00100093, ITYPE, 5'd1);
    push(32'h00200093, ITYPE, 5'd2);
    chk("bp_rdy32", 64'(rdy32), 64'd0);
    cur.inst = 32'h00300093; cur.typ = ITYPE; cur.tag = 5'd3; in_valid = 1'b1;
    cycle();
    chk("bp_hold_tag", 64'(tag32), 64'd1);
    out_ready = 1'b1;
    cycle();
    chk("bp_order2", 64'(tag32), 64'd2);
    cycle();
    chk("bp_order3", 64'(tag32), 64'd3);
    in_valid = 1'b0;
    drain();

    // Flush with both registers full and a new offer.
    push(32'h00500093, ITYPE, 5'd10);
    push(32'h00600093, ITYPE, 5'd11);
    cur.inst = 32'h00700093; cur.tag = 5'd12; in_valid = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_vld32", 64'(vld32), 64'd0);
    chk("flush_rdy32", 64'(rdy32), 64'd1);
    out_ready = 1'b1;
    cycle();
    chk("flush_nodeliv", 64'(vld64), 64'd0);
    out_ready = 1'b0;

    // Reset with entries held.
    push(32'h03F00013, SHTYPE, 5'd13);
    push(32'h00800093, ITYPE, 5'd14);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst2_vld32", 64'(vld32), 64'd0);
    chk("rst2_rdy32", 64'(rdy32), 64'd1);
    chk("rst2_imm32", 64'(imm32), 64'd0);

    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cur.inst  = $urandom;
      cur.typ   = 3'($urandom_range(0, 7));
      cur.tag   = 5'($urandom);
      cycle();
    end
    rst = 1'b0; flush = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
